imem_loader: RTL and testbench
==============================

# imem_loader

Hardware program loader that receives a framed byte stream and writes it as 32-bit instruction words into the TinyRISC instruction memory, starting at word address 0. It holds the pipeline in reset until a complete image has been written and its checksum verified. It replaces the simulation-only memory preload with a synthesizable boot path. It sits between a byte source (UART receiver or debug port) and the write port of the IF-stage instruction memory.

## Interface
Parameters:
- ADDR_WIDTH, 8, instruction memory word-address width; depth = 2^ADDR_WIDTH words

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset (asserted when 0)
- start  in  1  one-cycle pulse; begins a new load
- in_data  in  8  stream byte
- in_valid  in  1  in_data valid
- in_ready  out  1  loader accepts a byte this cycle
- imem_we  out  1  instruction memory write enable, one cycle per word
- imem_addr  out  ADDR_WIDTH  word address of the write
- imem_wdata  out  32  instruction word
- core_hold  out  1  drives pipeline reset; 1 = core held
- load_done  out  1  image loaded and verified (level)
- load_err  out  1  load failed (level)

## Operation
- Frame layout:
  - CNT_LO, CNT_HI: 16-bit word count N, little-endian
  - N×4 payload bytes, each word little-endian (first byte is bits [7:0])
  - CSUM: XOR of all payload bytes only
- A byte is accepted when in_valid && in_ready.
- States and transitions:
  - IDLE → HDR0 on start.
  - HDR0 → HDR1 on accept; byte latched as count[7:0].
  - HDR1 → DATA on accept; byte latched as count[15:8].
    - HDR1 → CSUM instead if the count is 0.
    - HDR1 → ERROR instead if the count > 2^ADDR_WIDTH.
  - DATA: accepts bytes into a shift assembler and updates the running XOR with each byte.
    - On the 4th byte of a word, issue a write.
    - After the write of word N-1, go to CSUM.
  - CSUM → DONE on accept if the byte equals the running XOR; otherwise → ERROR.
  - DONE, ERROR → HDR0 on start.
- start in any state other than IDLE, DONE or ERROR is ignored.
- On entering HDR0, clear:
  - byte counter
  - word address (to 0)
  - running XOR
  - load_done and load_err
- in_ready = 1 in HDR0, HDR1, DATA and CSUM; 0 otherwise.
- core_hold = 0 only in DONE; it is 1 in all other states, including ERROR.
- load_done = 1 only in DONE; load_err = 1 only in ERROR.
- Reset values:
  - state IDLE
  - in_ready 0, imem_we 0, imem_addr 0, imem_wdata 0
  - core_hold 1, load_done 0, load_err 0
- Reset mid-load: returns to IDLE immediately. Words already written stay in memory. The core stays held.

## Timing
- imem_we is registered. It pulses 1 cycle in the cycle after the handshake of a word's 4th byte. imem_addr and imem_wdata are valid in that same cycle.
- imem_addr is k for the k-th word (0-based) and increments after each write. At N = 2^ADDR_WIDTH the last address is 2^ADDR_WIDTH-1; the counter does not wrap before the transition to CSUM.
- A sustained in_valid gives 1 byte/cycle with no bubbles. A load of N words takes 2+4N+1 accepted bytes.
- in_valid gaps at any point are tolerated; the state is held.
- CSUM byte accepted in cycle t:
  - on a match, state is DONE at t+1, so core_hold falls and load_done rises in that cycle;
  - on a mismatch, load_err rises at t+1.
- The last data write (cycle after byte 4N) completes before the CSUM byte can be accepted, so it always precedes core_hold release.

## Test plan
- Reset, then start; send N=2, words 0x00000013 and 0x00A00093 (bytes 13 00 00 00 93 00 A0 00), then CSUM 0x20 → 2 writes at addr 0,1 with those data; load_done=1, core_hold=0 the cycle after CSUM.
- Same frame with CSUM 0x21 → both writes occur; load_err=1, core_hold stays 1; then start and a valid frame → load_done=1, load_err=0.
- N=0, CSUM 0x00 → no imem_we; DONE. N=257 with ADDR_WIDTH=8 → ERROR right after CNT_HI, in_ready=0.
- N=3 with random in_valid gaps → writes at addr 0..2 with correct data, one imem_we per word, no duplicate or dropped bytes.
- Assert rst during the 2nd word of a 4-word load → all outputs return to reset values asynchronously; a later start reloads correctly from addr 0.
- start pulsed mid-DATA → ignored; the load completes normally.

Source files
------------

// File: rtl/imem_loader.sv
`default_nettype none
// =============================================================================
// Module   : imem_loader
// Purpose  : Writes a framed byte stream into instruction memory as 32-bit words
//            and holds the core in reset until the checksum of the image matches.
// Revision : 1.0  initial release
// =============================================================================
module imem_loader #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  core_hold,
    output logic                  load_done,
    output logic                  load_err
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_HDR0  = 3'd1;
    localparam logic [2:0] S_HDR1  = 3'd2;
    localparam logic [2:0] S_DATA  = 3'd3;
    localparam logic [2:0] S_CSUM  = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;
    localparam logic [2:0] S_ERROR = 3'd6;

    localparam logic [16:0]           C_MAX_WORDS = 17'd1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] C_ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    logic [2:0]            state_q,      state_d;
    logic [7:0]            cnt_lo_q,     cnt_lo_d;
    logic [15:0]           words_left_q, words_left_d;
    logic [1:0]            byte_cnt_q,   byte_cnt_d;
    logic [23:0]           shift_q,      shift_d;
    logic [7:0]            csum_q,       csum_d;
    logic [ADDR_WIDTH-1:0] waddr_q,      waddr_d;
    logic                  imem_we_q,    imem_we_d;
    logic [ADDR_WIDTH-1:0] imem_addr_q,  imem_addr_d;
    logic [31:0]           imem_wdata_q, imem_wdata_d;

    logic        accept;
    logic        start_ok;
    logic        word_last_byte;
    logic [15:0] hdr_count;

    assign accept         = in_valid && in_ready;
    assign start_ok       = start && ((state_q == S_IDLE) || (state_q == S_DONE) ||
                                      (state_q == S_ERROR));
    assign word_last_byte = (byte_cnt_q == 2'd3);
    assign hdr_count      = {in_data, cnt_lo_q};

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            cnt_lo_q     <= 8'd0;
            words_left_q <= 16'd0;
            byte_cnt_q   <= 2'd0;
            shift_q      <= 24'd0;
            csum_q       <= 8'd0;
            waddr_q      <= '0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            cnt_lo_q     <= cnt_lo_d;
            words_left_q <= words_left_d;
            byte_cnt_q   <= byte_cnt_d;
            shift_q      <= shift_d;
            csum_q       <= csum_d;
            waddr_q      <= waddr_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start_ok) begin
                    state_d = S_HDR0;
                end
            end
            S_HDR0: begin
                if (accept) begin
                    state_d = S_HDR1;
                end
            end
            S_HDR1: begin
                if (accept) begin
                    if (hdr_count == 16'd0) begin
                        state_d = S_CSUM;
                    end else if ({1'b0, hdr_count} > C_MAX_WORDS) begin
                        state_d = S_ERROR;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept && word_last_byte && (words_left_q == 16'd1)) begin
                    state_d = S_CSUM;
                end
            end
            S_CSUM: begin
                if (accept) begin
                    state_d = (in_data == csum_q) ? S_DONE : S_ERROR;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath: header capture, word assembly, running XOR, memory write
    // -------------------------------------------------------------------------
    always_comb begin
        cnt_lo_d     = cnt_lo_q;
        words_left_d = words_left_q;
        byte_cnt_d   = byte_cnt_q;
        shift_d      = shift_q;
        csum_d       = csum_q;
        waddr_d      = waddr_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;

        if (start_ok) begin
            byte_cnt_d  = 2'd0;
            csum_d      = 8'd0;
            waddr_d     = '0;
            imem_addr_d = '0;
        end

        if (accept) begin
            case (state_q)
                S_HDR0: cnt_lo_d = in_data;
                S_HDR1: words_left_d = hdr_count;
                S_DATA: begin
                    csum_d     = csum_q ^ in_data;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    // Bytes arrive LSB first, so shift them in from the top.
                    if (word_last_byte) begin
                        imem_we_d    = 1'b1;
                        imem_addr_d  = waddr_q;
                        imem_wdata_d = {in_data, shift_q};
                        waddr_d      = waddr_q + C_ADDR_ONE;
                        words_left_d = words_left_q - 16'd1;
                    end else begin
                        shift_d = {in_data, shift_q[23:8]};
                    end
                end
                default: ;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    always_comb begin
        in_ready  = 1'b0;
        core_hold = 1'b1;
        load_done = 1'b0;
        load_err  = 1'b0;
        case (state_q)
            S_HDR0, S_HDR1, S_DATA, S_CSUM: in_ready = 1'b1;
            S_DONE: begin
                core_hold = 1'b0;
                load_done = 1'b1;
            end
            S_ERROR: load_err = 1'b1;
            default: ;
        endcase
    end

    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// =============================================================================
// Module   : tb_imem_loader
// Purpose  : Self-checking bench for imem_loader using a frame-level reference.
// Revision : 1.0  initial release
// =============================================================================
module tb_imem_loader;

    localparam int AW    = 8;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          core_hold;
    logic          load_done;
    logic          load_err;

    imem_loader #(.ADDR_WIDTH(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .imem_we   (imem_we),
        .imem_addr (imem_addr),
        .imem_wdata(imem_wdata),
        .core_hold (core_hold),
        .load_done (load_done),
        .load_err  (load_err)
    );

    always #5 clk = ~clk;

    int          ntests = 0;
    int          nfail  = 0;
    bit          mon_en = 1'b0;
    bit          exp_we_next = 1'b0;
    bit          last_ready = 1'b0;
    int          acc_idx = 0;
    int          cur_n = 0;
    logic [31:0] words_q[$];
    logic [7:0]  frame_q[$];
    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Stream-position model: the word write follows byte 4k+3 of the payload.
    task automatic mon_sample();
        chk("we_timing", {31'd0, imem_we}, {31'd0, exp_we_next});
        if (imem_we === 1'b1) begin
            chk("write_expected", (exp_addr.size() > 0) ? 32'd1 : 32'd0, 32'd1);
            if (exp_addr.size() > 0) begin
                chk("write_addr", {{(32-AW){1'b0}}, imem_addr}, exp_addr.pop_front());
                chk("write_data", imem_wdata, exp_data.pop_front());
            end
        end
        exp_we_next = 1'b0;
        if (in_valid && in_ready) begin
            if (acc_idx >= 2 && acc_idx < 2 + 4 * cur_n && ((acc_idx - 2) % 4) == 3)
                exp_we_next = 1'b1;
            acc_idx++;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (mon_en) mon_sample();
        last_ready = in_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap_max);
        int g;
        int waited;
        g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
        repeat (g) begin
            in_data = 8'($urandom);
            tick();
        end
        in_data  = b;
        in_valid = 1'b1;
        waited   = 0;
        do begin
            tick();
            waited++;
        end while (!last_ready && waited < 50);
        in_valid = 1'b0;
        chk("handshake", {31'd0, last_ready}, 32'd1);
    endtask

    task automatic check_reset_outputs(input string where);
        chk({where, "_in_ready"},  {31'd0, in_ready},  32'd0);
        chk({where, "_imem_we"},   {31'd0, imem_we},   32'd0);
        chk({where, "_imem_addr"}, {{(32-AW){1'b0}}, imem_addr}, 32'd0);
        chk({where, "_imem_wdata"}, imem_wdata,        32'd0);
        chk({where, "_core_hold"}, {31'd0, core_hold}, 32'd1);
        chk({where, "_load_done"}, {31'd0, load_done}, 32'd0);
        chk({where, "_load_err"},  {31'd0, load_err},  32'd0);
    endtask

    task automatic fill_random(input int n);
        words_q.delete();
        repeat (n) words_q.push_back($urandom);
    endtask

    // Builds the frame from words_q, streams it and checks the load outcome.
    task automatic run_frame(input int n, input logic [7:0] csum_xor, input int gap_max,
                             input int start_at, input int rst_at);
        logic [7:0]  x;
        logic [7:0]  b;
        logic [31:0] w;
        bit          exp_ok;
        frame_q.delete();
        exp_addr.delete();
        exp_data.delete();
        x = 8'h00;
        frame_q.push_back(n[7:0]);
        frame_q.push_back(n[15:8]);
        if (n <= DEPTH) begin
            for (int k = 0; k < n; k++) begin
                w = words_q[k];
                exp_addr.push_back(k);
                exp_data.push_back(w);
                for (int j = 0; j < 4; j++) begin
                    b = w[8*j +: 8];
                    frame_q.push_back(b);
                    x = x ^ b;
                end
            end
            frame_q.push_back(x ^ csum_xor);
        end
        exp_ok = (n <= DEPTH) && (csum_xor == 8'h00);

        acc_idx     = 0;
        exp_we_next = 1'b0;
        cur_n       = n;
        mon_en      = 1'b1;
        pulse_start();
        chk("start_in_ready",  {31'd0, in_ready},  32'd1);
        chk("start_load_done", {31'd0, load_done}, 32'd0);
        chk("start_load_err",  {31'd0, load_err},  32'd0);
        chk("start_core_hold", {31'd0, core_hold}, 32'd1);

        for (int i = 0; i < frame_q.size(); i++) begin
            if (i == start_at) pulse_start();
            if (i == rst_at) begin
                #2;
                rst    = 1'b0;
                mon_en = 1'b0;
                #1;
                check_reset_outputs("midrst");
                tick();
                rst = 1'b1;
                tick();
                check_reset_outputs("after_rst");
                return;
            end
            send_byte(frame_q[i], gap_max);
        end

        chk("done_level",  {31'd0, load_done}, {31'd0, exp_ok});
        chk("err_level",   {31'd0, load_err},  {31'd0, !exp_ok});
        chk("core_hold",   {31'd0, core_hold}, {31'd0, !exp_ok});
        chk("final_ready", {31'd0, in_ready},  32'd0);
        chk("writes_missing", exp_addr.size(), 0);
        tick();
        chk("hold_ready", {31'd0, in_ready}, 32'd0);
        mon_en = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        rst      = 1'b1;
        #1;
        rst = 1'b0;
        #2;
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst = 1'b1;
        tick();
        check_reset_outputs("idle");

        // Directed image: two words, correct and then corrupted checksum.
        words_q = '{32'h0000_0013, 32'h00A0_0093};
        run_frame(2, 8'h00, 0, -1, -1);
        run_frame(2, 8'h01, 0, -1, -1);
        run_frame(2, 8'h00, 0, -1, -1);

        // Empty image and an oversize count.
        run_frame(0, 8'h00, 0, -1, -1);
        run_frame(DEPTH + 1, 8'h00, 0, -1, -1);

        // Random input gaps.
        fill_random(3);
        run_frame(3, 8'h00, 3, -1, -1);

        // Reset in the middle of the second word, then reload.
        fill_random(4);
        run_frame(4, 8'h00, 0, -1, 7);
        run_frame(4, 8'h00, 1, -1, -1);

        // start during DATA must be ignored.
        fill_random(5);
        run_frame(5, 8'h00, 0, 9, -1);

        for (int it = 0; it < 6; it++) begin
            int          n;
            logic [7:0]  m;
            n = int'($urandom_range(12, 1));
            m = ($urandom_range(2, 0) == 0) ? 8'($urandom_range(255, 1)) : 8'h00;
            fill_random(n);
            run_frame(n, m, int'($urandom_range(2, 0)), -1, -1);
        end

        // Full-depth image reaches the last address.
        fill_random(DEPTH);
        run_frame(DEPTH, 8'h00, 0, -1, -1);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
`default_nettype wire
